// File: rtl/hb_dec2_pkg.sv
// Shared constants and types for the half-band decimate-by-2 stage.
// The coefficient set and widths assume the fixed 11-tap configuration.
package hb_dec2_pkg;

   localparam int HB_DATA_WIDTH = 16;
   localparam int HB_COEF_WIDTH = 16;
   localparam int HB_TAP_LEN    = 11;

   // Pre-added operand carries one extra bit; accumulator adds two guard bits.
   localparam int PRE_WIDTH = HB_DATA_WIDTH + 1;
   localparam int ACC_WIDTH = HB_DATA_WIDTH + 1 + HB_COEF_WIDTH + 2;

   // Q15 half-band taps, symmetric; odd taps other than the centre are zero.
   localparam logic signed [HB_COEF_WIDTH-1:0] HB_COEF [HB_TAP_LEN] = '{
      16'sd294, 16'sd0, -16'sd1876, 16'sd0, 16'sd9774, 16'sd16384,
      16'sd9774, 16'sd0, -16'sd1876, 16'sd0, 16'sd294
   };

   localparam logic signed [HB_DATA_WIDTH-1:0] Q15_MAX = 16'sh7FFF;
   localparam logic signed [HB_DATA_WIDTH-1:0] Q15_MIN = 16'sh8000;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      MAC0 = 3'd2,
      MAC1 = 3'd3,
      MAC2 = 3'd4,
      CNTR = 3'd5,
      OUT  = 3'd6
   } hb_state_t;

endpackage

// File: rtl/hb_dec2_mac.sv
// Single multiplier accumulate for the half-band stage: acc += operand * coef.
// clear has priority over enable so a new output can start from zero.
module hb_dec2_mac
   import hb_dec2_pkg::*;
#(
   parameter int PRE_W  = PRE_WIDTH,
   parameter int COEF_W = HB_COEF_WIDTH,
   parameter int ACC_W  = ACC_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     enable,
   input  logic signed [PRE_W-1:0]  operand,
   input  logic signed [COEF_W-1:0] coef,
   output logic signed [ACC_W-1:0]  acc
);

   logic signed [PRE_W+COEF_W-1:0] prod;

   assign prod = operand * coef;

   // Accumulate one partial product per enabled cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc + ACC_W'(prod);
      end
   end

endmodule

// File: rtl/hb_dec2_stage2.sv
// Half-band FIR, decimate by 2, feeding the 1/7 polyphase stage.
// One pre-add MAC is time-multiplexed by the FSM below.
// Optional build macro HB_DEC2_SAT_CNT_EN adds the sat_cnt clip counter port.
//
//   state | meaning
//   IDLE  | waiting for an odd-sample trigger
//   LOAD  | snapshot pre-added operands and centre tap, clear accumulator
//   MAC0  | acc += (x0 + x10) * h0
//   MAC1  | acc += (x2 + x8)  * h2
//   MAC2  | acc += (x4 + x6)  * h4
//   CNTR  | acc += x5 * h5
//   OUT   | round, saturate, register dout / dout_valid / sat
//
// OUT is the final cycle of a computation: the accumulator is consumed on
// its exit edge, so a trigger landing there starts the next one directly.
// That is what allows triggers exactly six cycles apart.
module hb_dec2_stage2
   import hb_dec2_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int COEF_WIDTH = 16,
   parameter int TAP_LEN    = 11
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         din_valid,
   input  logic signed [DATA_WIDTH-1:0] din,
   output logic                         dout_valid,
   output logic signed [DATA_WIDTH-1:0] dout,
   output logic                         sat,
   output logic                         overrun
`ifdef HB_DEC2_SAT_CNT_EN
   ,
   output logic [15:0]                  sat_cnt
`endif
);

   localparam int PRE_W = DATA_WIDTH + 1;
   localparam int ACC_W = DATA_WIDTH + 1 + COEF_WIDTH + 2;
   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (COEF_WIDTH - 2);

   logic signed [DATA_WIDTH-1:0] x [TAP_LEN];
   logic                         phase;
   hb_state_t                    state;
   logic signed [PRE_W-1:0]      p0, p1, p2;
   logic signed [DATA_WIDTH-1:0] xc;
   logic                         trigger;
   logic                         busy;

   logic                         mac_clear;
   logic                         mac_en;
   logic signed [PRE_W-1:0]      mac_op;
   logic signed [COEF_WIDTH-1:0] mac_coef;
   logic signed [ACC_W-1:0]      acc;

   logic signed [ACC_W-1:0]      acc_sh;
   logic                         clip;
   logic signed [DATA_WIDTH-1:0] y_sat;

   assign trigger = din_valid & phase;
   assign busy    = (state != IDLE) && (state != OUT);

   // Delay line and decimation phase; shifts on every accepted sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < TAP_LEN; k++) begin
            x[k] <= '0;
         end
         phase <= 1'b0;
      end else if (din_valid) begin
         x[0] <= din;
         for (int k = 1; k < TAP_LEN; k++) begin
            x[k] <= x[k-1];
         end
         phase <= ~phase;
      end
   end

   // Sequence the MAC through the three pre-added pairs and the centre tap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         p0         <= '0;
         p1         <= '0;
         p2         <= '0;
         xc         <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         sat        <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         sat        <= 1'b0;
         if (trigger && busy) begin
            overrun <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (trigger) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               p0    <= {x[0][DATA_WIDTH-1], x[0]} + {x[10][DATA_WIDTH-1], x[10]};
               p1    <= {x[2][DATA_WIDTH-1], x[2]} + {x[8][DATA_WIDTH-1], x[8]};
               p2    <= {x[4][DATA_WIDTH-1], x[4]} + {x[6][DATA_WIDTH-1], x[6]};
               xc    <= x[5];
               state <= MAC0;
            end
            MAC0: state <= MAC1;
            MAC1: state <= MAC2;
            MAC2: state <= CNTR;
            CNTR: state <= OUT;
            OUT: begin
               dout       <= y_sat;
               dout_valid <= 1'b1;
               sat        <= clip;
               state      <= trigger ? LOAD : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Steer the single multiplier's operand and coefficient by state.
   always_comb begin
      mac_clear = (state == LOAD);
      mac_en    = 1'b0;
      mac_op    = '0;
      mac_coef  = '0;
      case (state)
         MAC0: begin
            mac_en   = 1'b1;
            mac_op   = p0;
            mac_coef = HB_COEF[0];
         end
         MAC1: begin
            mac_en   = 1'b1;
            mac_op   = p1;
            mac_coef = HB_COEF[2];
         end
         MAC2: begin
            mac_en   = 1'b1;
            mac_op   = p2;
            mac_coef = HB_COEF[4];
         end
         CNTR: begin
            mac_en   = 1'b1;
            mac_op   = {xc[DATA_WIDTH-1], xc};
            mac_coef = HB_COEF[5];
         end
         default: ;
      endcase
   end

   // Round half up, then clip to the output range when the upper bits disagree.
   always_comb begin
      acc_sh = (acc + RND_HALF) >>> (COEF_WIDTH - 1);
      clip   = !((&acc_sh[ACC_W-1:DATA_WIDTH-1]) || !(|acc_sh[ACC_W-1:DATA_WIDTH-1]));
      if (clip) begin
         y_sat = acc_sh[ACC_W-1] ? Q15_MIN : Q15_MAX;
      end else begin
         y_sat = acc_sh[DATA_WIDTH-1:0];
      end
   end

   hb_dec2_mac #(
      .PRE_W  (PRE_W),
      .COEF_W (COEF_WIDTH),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clear   (mac_clear),
      .enable  (mac_en),
      .operand (mac_op),
      .coef    (mac_coef),
      .acc     (acc)
   );

`ifdef HB_DEC2_SAT_CNT_EN
   // Count clipped outputs, holding at full scale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt <= '0;
      end else if (dout_valid && sat && (sat_cnt != 16'hFFFF)) begin
         sat_cnt <= sat_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hb_dec2_stage2.sv
// Directed bench for hb_dec2_stage2: reset, impulse, DC, clipping,
// overrun and reset-abort scenarios with hand-computed outputs.
module tb_hb_dec2_stage2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               din_valid = 1'b0;
   logic signed [15:0] din = '0;
   logic               dout_valid;
   logic signed [15:0] dout;
   logic               sat;
   logic               overrun;
`ifdef HB_DEC2_SAT_CNT_EN
   logic [15:0]        sat_cnt;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   int n_smp = 0;
   int sat_stray = 0;

   logic signed [15:0] q_dout [$];
   logic               q_sat  [$];
   int                 q_cyc  [$];
   int                 q_trig [$];

   hb_dec2_stage2 dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din        (din),
      .dout_valid (dout_valid),
      .dout       (dout),
      .sat        (sat),
      .overrun    (overrun)
`ifdef HB_DEC2_SAT_CNT_EN
      ,
      .sat_cnt    (sat_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dout_valid) begin
         q_dout.push_back(dout);
         q_sat.push_back(sat);
         q_cyc.push_back(cyc);
      end else if (sat) begin
         sat_stray <= sat_stray + 1;
      end
   end

   task automatic apply_reset();
      rst       = 1'b1;
      din_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst   = 1'b0;
      n_smp = 0;
   endtask

   task automatic send(input logic signed [15:0] s, input int gap);
      din       = s;
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      din       = '0;
      if (n_smp % 2 == 1) q_trig.push_back(cyc);
      n_smp++;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic test_reset();
      int db;
      db = q_dout.size();
      apply_reset();
      din = 16'sh1234;
      repeat (20) @(negedge clk);
      din = '0;
      vec_cnt++;
      if (dout !== 16'sd0) begin
         err_cnt++; $display("FAIL reset_dout: got %0d want 0", dout);
      end
      vec_cnt++;
      if (q_dout.size() - db !== 0) begin
         err_cnt++; $display("FAIL reset_no_valid: got %0d strobes want 0", q_dout.size() - db);
      end
      vec_cnt++;
      if (overrun !== 1'b0) begin
         err_cnt++; $display("FAIL reset_overrun: got %b want 0", overrun);
      end
      vec_cnt++;
      if (sat !== 1'b0) begin
         err_cnt++; $display("FAIL reset_sat: got %b want 0", sat);
      end
   endtask

   task automatic test_impulse();
      logic signed [15:0] exp_y [6] = '{16'sd147, -16'sd938, 16'sd4887, 16'sd4887, -16'sd938, 16'sd147};
      int db, tb, cnt;
      apply_reset();
      db = q_dout.size();
      tb = q_trig.size();
      for (int n = 0; n < 12; n++) send((n == 1) ? 16'sd16384 : 16'sd0, 4);
      repeat (10) @(negedge clk);
      cnt = q_dout.size() - db;
      vec_cnt++;
      if (cnt !== 6) begin
         err_cnt++; $display("FAIL impulse_count: got %0d want 6", cnt);
      end
      for (int i = 0; i < 6 && i < cnt; i++) begin
         vec_cnt++;
         if (q_dout[db+i] !== exp_y[i]) begin
            err_cnt++; $display("FAIL impulse_y[%0d]: got %0d want %0d", i, q_dout[db+i], exp_y[i]);
         end
         vec_cnt++;
         if (q_sat[db+i] !== 1'b0) begin
            err_cnt++; $display("FAIL impulse_sat[%0d]: got %b want 0", i, q_sat[db+i]);
         end
         vec_cnt++;
         if (q_cyc[db+i] - q_trig[tb+i] !== 6) begin
            err_cnt++; $display("FAIL impulse_latency[%0d]: got %0d want 6", i, q_cyc[db+i] - q_trig[tb+i]);
         end
      end
      vec_cnt++;
      if (overrun !== 1'b0) begin
         err_cnt++; $display("FAIL impulse_overrun: got %b want 0", overrun);
      end
   endtask

   task automatic test_dc();
      int db, ss, cnt;
      apply_reset();
      db = q_dout.size();
      ss = sat_stray;
      for (int n = 0; n < 30; n++) send(16'sd10000, 3);
      repeat (10) @(negedge clk);
      cnt = q_dout.size() - db;
      vec_cnt++;
      if (cnt !== 15) begin
         err_cnt++; $display("FAIL dc_count: got %0d want 15", cnt);
      end
      for (int i = 0; i < 15 && i < cnt; i++) begin
         if (i >= 5) begin
            vec_cnt++;
            if (q_dout[db+i] !== 16'sd10000) begin
               err_cnt++; $display("FAIL dc_y[n=%0d]: got %0d want 10000", 2*i+1, q_dout[db+i]);
            end
         end
         vec_cnt++;
         if (q_sat[db+i] !== 1'b0) begin
            err_cnt++; $display("FAIL dc_sat[n=%0d]: got %b want 0", 2*i+1, q_sat[db+i]);
         end
      end
      vec_cnt++;
      if (overrun !== 1'b0) begin
         err_cnt++; $display("FAIL dc_overrun: got %b want 0", overrun);
      end
      vec_cnt++;
      if (sat_stray - ss !== 0) begin
         err_cnt++; $display("FAIL dc_sat_idle: got %0d stray cycles want 0", sat_stray - ss);
      end
   endtask

   task automatic test_saturation(input bit neg);
      logic signed [15:0] pat [12] = '{16'sd0, 16'sd32767, 16'sd0, -16'sd32768, 16'sd0, 16'sd32767,
                                       16'sd32767, 16'sd32767, 16'sd0, -16'sd32768, 16'sd0, 16'sd32767};
      logic signed [15:0] s, want;
      int db, cnt;
      apply_reset();
      db   = q_dout.size();
      want = neg ? -16'sd32768 : 16'sd32767;
      for (int n = 0; n < 12; n++) begin
         s = pat[n];
         if (neg) s = (s == 16'sd32767) ? -16'sd32768 : ((s == -16'sd32768) ? 16'sd32767 : s);
         send(s, 3);
      end
      repeat (10) @(negedge clk);
      cnt = q_dout.size() - db;
      vec_cnt++;
      if (cnt !== 6) begin
         err_cnt++; $display("FAIL sat%0d_count: got %0d want 6", neg, cnt);
      end
      if (cnt >= 6) begin
         vec_cnt++;
         if (q_dout[db+5] !== want) begin
            err_cnt++; $display("FAIL sat%0d_y11: got %0d want %0d", neg, q_dout[db+5], want);
         end
         vec_cnt++;
         if (q_sat[db+5] !== 1'b1) begin
            err_cnt++; $display("FAIL sat%0d_flag: got %b want 1", neg, q_sat[db+5]);
         end
         vec_cnt++;
         if (q_sat[db+4] !== 1'b0) begin
            err_cnt++; $display("FAIL sat%0d_flag_n9: got %b want 0", neg, q_sat[db+4]);
         end
      end
      vec_cnt++;
      if (dout !== want) begin
         err_cnt++; $display("FAIL sat%0d_hold: got %0d want %0d", neg, dout, want);
      end
      vec_cnt++;
      if (sat !== 1'b0) begin
         err_cnt++; $display("FAIL sat%0d_idle_sat: got %b want 0", neg, sat);
      end
`ifdef HB_DEC2_SAT_CNT_EN
      vec_cnt++;
      if (sat_cnt !== 16'd1) begin
         err_cnt++; $display("FAIL sat%0d_cnt: got %0d want 1", neg, sat_cnt);
      end
`endif
   endtask

   task automatic test_overrun();
      int db, tb, cnt;
      apply_reset();
      db = q_dout.size();
      tb = q_trig.size();
      for (int n = 0; n < 4; n++) send(16'sd1000, 1);
      repeat (12) @(negedge clk);
      cnt = q_dout.size() - db;
      vec_cnt++;
      if (overrun !== 1'b1) begin
         err_cnt++; $display("FAIL overrun_set: got %b want 1", overrun);
      end
      vec_cnt++;
      if (cnt !== 1) begin
         err_cnt++; $display("FAIL overrun_count: got %0d want 1", cnt);
      end
      if (cnt >= 1) begin
         vec_cnt++;
         if (q_dout[db] !== 16'sd9) begin
            err_cnt++; $display("FAIL overrun_y1: got %0d want 9", q_dout[db]);
         end
         vec_cnt++;
         if (q_cyc[db] - q_trig[tb] !== 6) begin
            err_cnt++; $display("FAIL overrun_latency: got %0d want 6", q_cyc[db] - q_trig[tb]);
         end
      end
      repeat (30) @(negedge clk);
      vec_cnt++;
      if (overrun !== 1'b1) begin
         err_cnt++; $display("FAIL overrun_sticky: got %b want 1", overrun);
      end
      apply_reset();
      vec_cnt++;
      if (overrun !== 1'b0) begin
         err_cnt++; $display("FAIL overrun_clear: got %b want 0", overrun);
      end
   endtask

   task automatic test_reset_mid();
      int db, cnt;
      apply_reset();
      for (int n = 0; n < 11; n++) send(16'sd20000, 3);
      repeat (10) @(negedge clk);
      db = q_dout.size();
      send(16'sd20000, 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      n_smp = 0;
      repeat (10) @(negedge clk);
      vec_cnt++;
      if (q_dout.size() - db !== 0) begin
         err_cnt++; $display("FAIL abort_no_valid: got %0d strobes want 0", q_dout.size() - db);
      end
      vec_cnt++;
      if (dout !== 16'sd0) begin
         err_cnt++; $display("FAIL abort_dout: got %0d want 0", dout);
      end
      db = q_dout.size();
      send(16'sd0, 4);
      send(16'sd16384, 4);
      repeat (10) @(negedge clk);
      cnt = q_dout.size() - db;
      vec_cnt++;
      if (cnt !== 1) begin
         err_cnt++; $display("FAIL abort_next_count: got %0d want 1", cnt);
      end
      if (cnt >= 1) begin
         vec_cnt++;
         if (q_dout[db] !== 16'sd147) begin
            err_cnt++; $display("FAIL abort_next_y: got %0d want 147", q_dout[db]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_dc();
      test_saturation(1'b0);
      test_saturation(1'b1);
      test_overrun();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
